// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jk_pkg
// Brief    : Shared state encoding and excitation-mode constants for the
//            JK sequence driver (optional JK_SEQ_DRIVER_FEEDBACK_EN in top).
// Revision : 1.0 - initial release
// ============================================================================
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int ENC_SETRST  = 0;
    localparam int ENC_HOLDTGL = 1;

endpackage : jk_pkg
`default_nettype wire

// File: rtl/jk_excite.sv
`default_nettype none
// ============================================================================
// Module   : jk_excite
// Brief    : Combinational JK excitation table: target bit and current state
//            in, J/K out, in set/reset or hold/toggle form.
// Revision : 1.0 - initial release
// ============================================================================
module jk_excite
    import jk_pkg::*;
#(
    parameter int ENC = ENC_SETRST
) (
    input  logic t,
    input  logic q_cur,
    output logic j,
    output logic k
);

    generate
        if (ENC == ENC_HOLDTGL) begin : g_holdtgl
            // Toggle only when the target differs from the present state.
            assign j = t ^ q_cur;
            assign k = t ^ q_cur;
        end else begin : g_setrst
            logic w_unused_q_cur;
            assign w_unused_q_cur = q_cur;
            assign j = t;
            assign k = ~t;
        end
    endgenerate

endmodule : jk_excite
`default_nettype wire

// File: rtl/jk_seq_driver.sv
`default_nettype none
// ============================================================================
// Module   : jk_seq_driver
// Brief    : Serialises a WIDTH-bit target sequence onto the J/K inputs of an
//            external JK flip-flop, LSB first, tracking its expected state.
//            Define JK_SEQ_DRIVER_FEEDBACK_EN to enable q_fb mismatch checking.
// Revision : 1.0 - initial release
// ============================================================================
module jk_seq_driver
    import jk_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ENC   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             q_fb,
    output logic             j,
    output logic             k,
    output logic             q_exp,
    output logic             busy,
    output logic             done,
    output logic             mismatch
);

    localparam int                 c_cnt_w = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shift;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_q_exp;
    logic               r_mismatch;
    logic               w_accept;
    logic               w_in_drive;
    logic               w_j;
    logic               w_k;
    logic               w_fb_err;

    assign w_in_drive = (r_state == DRIVE);
    assign w_accept   = in_valid && (r_state == IDLE);

    jk_excite #(
        .ENC   (ENC)
    ) u_excite (
        .t     (r_shift[0]),
        .q_cur (r_q_exp),
        .j     (w_j),
        .k     (w_k)
    );

`ifdef JK_SEQ_DRIVER_FEEDBACK_EN
    assign w_fb_err = (r_state != IDLE) && (q_fb != r_q_exp);
`else
    logic w_unused_q_fb;
    assign w_unused_q_fb = q_fb;
    assign w_fb_err      = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = DRIVE;
            DRIVE:   if (r_cnt == c_last) w_state_nxt = CHECK;
            CHECK:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_q_exp    <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_shift <= in_data;
                r_cnt   <= '0;
            end else if (w_in_drive) begin
                r_q_exp <= r_shift[0];
                r_shift <= r_shift >> 1;
                r_cnt   <= r_cnt + c_one;
            end
            // Sticky until the next accepted transfer.
            if (w_accept) begin
                r_mismatch <= 1'b0;
            end else if (w_fb_err) begin
                r_mismatch <= 1'b1;
            end
        end
    end

    assign in_ready = (r_state == IDLE);
    assign busy     = (r_state == DRIVE) || (r_state == CHECK);
    assign done     = (r_state == CHECK);
    assign j        = w_in_drive && w_j;
    assign k        = w_in_drive && w_k;
    assign q_exp    = r_q_exp;
    assign mismatch = r_mismatch;

endmodule : jk_seq_driver
`default_nettype wire

// File: tb/tb_jk_seq_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_seq_driver
// Brief    : Self-checking bench for jk_seq_driver with both encodings, each
//            driving its own JK flip-flop model (JK_SEQ_DRIVER_FEEDBACK_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk_seq_driver;

    localparam int WIDTH = 8;
`ifdef JK_SEQ_DRIVER_FEEDBACK_EN
    localparam bit c_fb = 1'b1;
`else
    localparam bit c_fb = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             force_zero;
    logic             rdy0, j0, k0, qe0, busy0, done0, mm0, ff0, qfb0;
    logic             rdy1, j1, k1, qe1, busy1, done1, mm1, ff1, qfb1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             exp_q;
        bit               frc;
    } vec_t;

    typedef struct {
        logic [1:0] jk0;
        logic [1:0] jk1;
        logic       qbit;
    } exp_t;

    vec_t       vecs [6];
    exp_t       sb [$];
    logic [1:0] a5_jk0 [8];
    logic [1:0] f0_jk1 [8];
    logic       model_q;

    always #5 clk = ~clk;

    assign qfb0 = force_zero ? 1'b0 : ff0;
    assign qfb1 = force_zero ? 1'b0 : ff1;

    // Reference JK flip-flops sharing clk/rst with the drivers.
    always @(posedge clk) begin
        if (rst) begin
            ff0 <= 1'b0;
            ff1 <= 1'b0;
        end else begin
            case ({j0, k0})
                2'b01:   ff0 <= 1'b0;
                2'b10:   ff0 <= 1'b1;
                2'b11:   ff0 <= ~ff0;
                default: ff0 <= ff0;
            endcase
            case ({j1, k1})
                2'b01:   ff1 <= 1'b0;
                2'b10:   ff1 <= 1'b1;
                2'b11:   ff1 <= ~ff1;
                default: ff1 <= ff1;
            endcase
        end
    end

    jk_seq_driver #(.WIDTH(WIDTH), .ENC(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy0), .q_fb(qfb0), .j(j0), .k(k0), .q_exp(qe0),
        .busy(busy0), .done(done0), .mismatch(mm0)
    );

    jk_seq_driver #(.WIDTH(WIDTH), .ENC(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .q_fb(qfb1), .j(j1), .k(k1), .q_exp(qe1),
        .busy(busy1), .done(done1), .mismatch(mm1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_transfer(input logic [WIDTH-1:0] d, input bit frc, input logic exp_q);
        exp_t e;
        logic mq, prev_q, cur_q, q_start, exp_mm, pend;
        bit   forced;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        check("ready_idle", {rdy1, rdy0}, 2'b11);
        q_start = model_q;
        mq      = model_q;
        for (int i = 0; i < WIDTH; i++) begin
            e.jk0  = d[i] ? 2'b10 : 2'b01;
            e.jk1  = (d[i] == mq) ? 2'b00 : 2'b11;
            e.qbit = d[i];
            sb.push_back(e);
            mq = d[i];
        end
        prev_q = q_start;
        exp_mm = 1'b0;
        pend   = 1'b0;
        forced = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            force_zero = 1'b0;
            if (i == 3) in_valid = 1'b0;
            if (pend) exp_mm = c_fb;
            pend  = 1'b0;
            cur_q = prev_q;
            check("mismatch_drive", {mm1, mm0}, {2{exp_mm}});
            if (i > 0) begin
                check("q_exp_step", {qe1, qe0}, {2{cur_q}});
                check("ff_q_step", {ff1, ff0}, {2{cur_q}});
            end
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("jk_seq", {j1, k1, j0, k0}, {e.jk1, e.jk0});
                prev_q = e.qbit;
            end
            if (d == 8'hA5) check("jk_a5_enc0", {j0, k0}, a5_jk0[i]);
            if (d == 8'h0F && q_start == 1'b0) check("jk_0f_enc1", {j1, k1}, f0_jk1[i]);
            check("flags_drive", {busy1, rdy1, done1, busy0, rdy0, done0}, 6'b100100);
            if (frc && !forced && cur_q == 1'b1) begin
                force_zero = 1'b1;
                forced     = 1'b1;
                pend       = 1'b1;
            end
        end
        @(negedge clk);
        force_zero = 1'b0;
        if (pend) exp_mm = c_fb;
        check("flags_check", {busy1, rdy1, done1, busy0, rdy0, done0}, 6'b101101);
        check("q_exp_final", {qe1, qe0}, {2{exp_q}});
        check("ff_q_final", {ff1, ff0}, {2{exp_q}});
        check("mismatch_done", {mm1, mm0}, {2{exp_mm}});
        check("jk_hold_check", {j1, k1, j0, k0}, 4'b0000);
        @(negedge clk);
        check("flags_idle", {busy1, rdy1, done1, busy0, rdy0, done0}, 6'b010010);
        check("mismatch_idle", {mm1, mm0}, {2{exp_mm}});
        check("jk_hold_idle", {j1, k1, j0, k0}, 4'b0000);
        model_q = prev_q;
    endtask

    initial begin
        int dones;
        a5_jk0 = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10};
        f0_jk1 = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00};
        vecs[0] = '{data: 8'h0F, exp_q: 1'b0, frc: 1'b0};
        vecs[1] = '{data: 8'hA5, exp_q: 1'b1, frc: 1'b0};
        vecs[2] = '{data: 8'h00, exp_q: 1'b0, frc: 1'b0};
        vecs[3] = '{data: 8'hFF, exp_q: 1'b1, frc: 1'b1};
        vecs[4] = '{data: 8'h3C, exp_q: 1'b0, frc: 1'b0};
        vecs[5] = '{data: 8'h81, exp_q: 1'b1, frc: 1'b1};

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        force_zero = 1'b0;
        model_q    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_flags", {busy1, rdy1, done1, busy0, rdy0, done0}, 6'b010010);
        check("reset_outs", {j1, k1, qe1, mm1, j0, k0, qe0, mm0}, 8'h00);

        for (int v = 0; v < 6; v++) begin
            do_transfer(vecs[v].data, vecs[v].frc, vecs[v].exp_q);
        end

        // in_valid held high: ready every tenth cycle only.
        @(negedge clk);
        in_data  = 8'h55;
        in_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            check("b2b_ready", {rdy1, rdy0}, {2{(c % 10) == 0}});
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_ready_end", {rdy1, rdy0}, 2'b11);
        check("b2b_q_exp", {qe1, qe0}, 2'b00);
        model_q = 1'b0;

        // Reset on the fourth DRIVE cycle aborts without done.
        in_data  = 8'hFF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_q", {qe1, qe0}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_flags", {busy1, rdy1, done1, busy0, rdy0, done0}, 6'b010010);
        check("abort_outs", {j1, k1, qe1, j0, k0, qe0}, 6'b000000);
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done0 || done1) dones++;
        end
        check("abort_no_done", dones, 0);
        model_q = 1'b0;

        do_transfer(8'hA5, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_jk_seq_driver
`default_nettype wire
